// File: rtl/clock_pkg.sv
// Shared definitions for the millisecond clock and the millisecond sleep service.
package clock_pkg;

    localparam int unsigned CLOCK_RATIO_DEFAULT = 200000;

    typedef enum logic [1:0] {
        IDLE,
        COUNT,
        DONE
    } sleep_state_t;

endpackage

// File: rtl/ms_prescaler.sv
// Mod-CLOCK_RATIO cycle counter producing a one-cycle tick per millisecond.
// Shared with the millisecond clock so both agree on what 1 ms is.
module ms_prescaler
    import clock_pkg::*;
#(
    parameter int unsigned CLOCK_RATIO = CLOCK_RATIO_DEFAULT
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic tick
);

    localparam logic [31:0] LAST_COUNT = 32'(CLOCK_RATIO - 1);

    logic [31:0] count_q;
    logic [31:0] count_d;

    // Clear wins over enable so a new call always starts on a fresh millisecond.
    always_comb begin
        count_d = count_q;
        tick    = 1'b0;
        if (clear) begin
            count_d = '0;
        end else if (enable) begin
            if (count_q == LAST_COUNT) begin
                count_d = '0;
                tick    = 1'b1;
            end else begin
                count_d = count_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/clock_sleep_ms.sv
// Blocking millisecond delay: counts ms_port milliseconds, then pulses done_port
// with the number of whole milliseconds elapsed (early if aborted).
module clock_sleep_ms
    import clock_pkg::*;
#(
    parameter int unsigned CLOCK_RATIO = CLOCK_RATIO_DEFAULT
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start_port,
    input  logic [31:0] ms_port,
    input  logic        abort_port,
    output logic        done_port,
    output logic [31:0] return_port,
    output logic        busy_port
);

    sleep_state_t state_q, state_d;
    logic [31:0]  remaining_q, remaining_d;
    logic [31:0]  elapsed_q, elapsed_d;
    logic [31:0]  return_q, return_d;
    logic         done_q, done_d;
    logic         busy_q, busy_d;
    logic         tick;

    ms_prescaler #(
        .CLOCK_RATIO(CLOCK_RATIO)
    ) u_prescaler (
        .clock (clock),
        .reset (reset),
        .clear (state_q != COUNT),
        .enable(state_q == COUNT),
        .tick  (tick)
    );

    // A tick in the finishing cycle is always counted, so the final tick and an
    // abort share one return formula: elapsed plus this cycle's tick.
    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        elapsed_d   = elapsed_q;
        return_d    = return_q;
        unique case (state_q)
            IDLE: begin
                if (start_port) begin
                    if (ms_port == 32'd0) begin
                        state_d  = DONE;
                        return_d = '0;
                    end else begin
                        state_d     = COUNT;
                        remaining_d = ms_port;
                        elapsed_d   = '0;
                    end
                end
            end
            COUNT: begin
                if (tick) begin
                    remaining_d = remaining_q - 32'd1;
                    elapsed_d   = elapsed_q + 32'd1;
                end
                if ((tick && remaining_q == 32'd1) || abort_port) begin
                    state_d  = DONE;
                    return_d = elapsed_q + {31'd0, tick};
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        done_d = (state_d == DONE);
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q     <= IDLE;
            remaining_q <= '0;
            elapsed_q   <= '0;
            return_q    <= '0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            elapsed_q   <= elapsed_d;
            return_q    <= return_d;
            done_q      <= done_d;
            busy_q      <= busy_d;
        end
    end

    assign done_port   = done_q;
    assign return_port = return_q;
    assign busy_port   = busy_q;

endmodule

// File: tb/tb_clock_sleep_ms.sv
// Directed, table-driven bench for clock_sleep_ms with CLOCK_RATIO=4.
module tb_clock_sleep_ms;

    logic        clock;
    logic        reset;
    logic        start_port;
    logic [31:0] ms_port;
    logic        abort_port;
    logic        done_port;
    logic [31:0] return_port;
    logic        busy_port;

    int compared;
    int mismatched;

    clock_sleep_ms #(
        .CLOCK_RATIO(4)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .start_port (start_port),
        .ms_port    (ms_port),
        .abort_port (abort_port),
        .done_port  (done_port),
        .return_port(return_port),
        .busy_port  (busy_port)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // One call: k counts edges after the accepting edge; done is expected in
    // the cycle after edge done_k. abort_k<0 means no abort, 0 means with start.
    typedef struct {
        logic [31:0] ms;
        int          abort_k;
        int          done_k;
        logic [31:0] ret;
        bit          noise;
    } vec_t;

    vec_t vecs[8];

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    task automatic run_call(input vec_t v);
        start_port = 1'b1;
        ms_port    = v.ms;
        abort_port = (v.abort_k == 0);
        step();
        for (int k = 0; k <= v.done_k + 1; k++) begin
            chk($sformatf("done ms=%0d k=%0d", v.ms, k), {31'd0, done_port}, {31'd0, k == v.done_k});
            chk($sformatf("busy ms=%0d k=%0d", v.ms, k), {31'd0, busy_port}, {31'd0, k <= v.done_k});
            if (k >= v.done_k)
                chk($sformatf("return ms=%0d k=%0d", v.ms, k), return_port, v.ret);
            if (k <= v.done_k) begin
                start_port = v.noise;
                ms_port    = v.noise ? 32'd7 : v.ms;
                abort_port = (v.abort_k == k + 1);
                step();
            end
        end
        start_port = 1'b0;
        abort_port = 1'b0;
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;

        //            ms     abort_k done_k ret    noise
        vecs[0] = '{32'd3,  -1,     12,    32'd3, 1'b0};
        vecs[1] = '{32'd0,  -1,     0,     32'd0, 1'b0};
        vecs[2] = '{32'd5,  10,     10,    32'd2, 1'b0};
        vecs[3] = '{32'd2,  8,      8,     32'd2, 1'b0};
        vecs[4] = '{32'd1,  0,      4,     32'd1, 1'b0};
        vecs[5] = '{32'd2,  4,      4,     32'd1, 1'b0};
        vecs[6] = '{32'd1,  1,      1,     32'd0, 1'b0};
        vecs[7] = '{32'd2,  -1,     8,     32'd2, 1'b1};

        reset      = 1'b0;
        start_port = 1'b0;
        ms_port    = '0;
        abort_port = 1'b0;
        step();
        step();
        chk("reset done", {31'd0, done_port}, 32'd0);
        chk("reset busy", {31'd0, busy_port}, 32'd0);
        chk("reset return", return_port, 32'd0);
        reset = 1'b1;
        step();

        for (int i = 0; i < 8; i++) begin
            run_call(vecs[i]);
            step();
        end

        // Start held high with ms=1 retriggers every 6 cycles.
        start_port = 1'b1;
        ms_port    = 32'd1;
        step();
        for (int k = 0; k <= 16; k++) begin
            chk($sformatf("held done k=%0d", k), {31'd0, done_port}, {31'd0, (k % 6) == 4});
            if (k == 16) start_port = 1'b0;
            step();
        end
        step();
        chk("held idle busy", {31'd0, busy_port}, 32'd0);
        chk("held return", return_port, 32'd1);

        // Reset mid-COUNT abandons the call without a done pulse.
        start_port = 1'b1;
        ms_port    = 32'd4;
        step();
        start_port = 1'b0;
        repeat (5) step();
        chk("mid busy", {31'd0, busy_port}, 32'd1);
        reset = 1'b0;
        step();
        chk("midreset done", {31'd0, done_port}, 32'd0);
        chk("midreset busy", {31'd0, busy_port}, 32'd0);
        chk("midreset return", return_port, 32'd0);
        reset = 1'b1;
        for (int k = 0; k < 20; k++) begin
            step();
            chk($sformatf("post-reset done k=%0d", k), {31'd0, done_port}, 32'd0);
        end
        run_call('{32'd1, -1, 4, 32'd1, 1'b0});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
